fp_minmax_reduce: RTL
=====================

FP_MINMAX_REDUCE -- requirements
Module: fp_minmax_reduce

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, operand width in bits (IEEE-754 double layout: sign [63], exponent [62:52], mantissa [51:0]).
REQ-002 SHALL have parameter CNT_WIDTH, default 16, width of the length and index fields.
REQ-003 in_clk  input  1  single clock; all state updates on rising edge.
REQ-004 in_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_start  input  1  one-cycle request to begin a reduction; sampled only in IDLE.
REQ-006 in_ctrl_minmax  input  1  operation select: 1 = maximum, 0 = minimum; latched with in_start.
REQ-007 in_len  input  CNT_WIDTH  number of elements to reduce; latched with in_start.
REQ-008 in_data_valid  input  1  in_data holds a valid element.
REQ-009 in_data  input  DATA_WIDTH  element stream.
REQ-010 out_data_ready  output  1  block accepts an element this cycle.
REQ-011 out_busy  output  1  high in every state except IDLE.
REQ-012 out_result_valid  output  1  out_result, out_result_idx and out_err are valid.
REQ-013 out_result  output  DATA_WIDTH  selected min/max element, bit-exact copy of the input.
REQ-014 out_result_idx  output  CNT_WIDTH  zero-based position of the selected element in the stream.
REQ-015 out_err  output  1  reduction requested with in_len = 0.
REQ-016 in_result_ready  input  1  consumer accepts the result.

Function
REQ-017 FSM states SHALL be IDLE, FIRST, RUN, DONE; exactly one state active.
REQ-018 IDLE: in_start=1 and in_len>0 -> FIRST; in_start=1 and in_len=0 -> DONE with out_err=1, out_result=0, out_result_idx=0; else stay.
REQ-019 An element SHALL transfer only on a cycle with in_data_valid=1 and out_data_ready=1; out_data_ready=1 exactly in FIRST and RUN.
REQ-020 FIRST: on transfer, element SHALL load the candidate register, candidate index=0, element counter=1; next state RUN if in_len>1, else DONE.
REQ-021 RUN: on transfer, element SHALL replace the candidate iff strictly greater (max) or strictly less (min) than the candidate; its index = current counter value; counter increments by 1.
REQ-022 RUN SHALL move to DONE on the transfer where counter+1 = latched length; in_data_valid low SHALL stall with no state change.
REQ-023 Ordering SHALL be sign-magnitude: negative < positive; same sign, compare {exponent,mantissa} as unsigned, reversed for negative; -0 < +0; NaN/Inf handled by bit pattern only, no special casing.
REQ-024 Ties SHALL keep the earlier element (lowest index).
REQ-025 DONE: out_result_valid=1; outputs SHALL hold stable until in_result_ready=1, then next state IDLE and out_result_valid=0.
REQ-026 Latency: out_result_valid SHALL assert the cycle after the last element transfer (or the cycle after in_start when in_len=0).
REQ-027 in_start outside IDLE, including the DONE->IDLE handshake cycle, SHALL be ignored.
REQ-028 in_ctrl_minmax and in_len changes after start SHALL have no effect on the running reduction.
REQ-029 Element counter SHALL be CNT_WIDTH bits; in_len = 2^CNT_WIDTH-1 SHALL complete without wrap.
REQ-030 out_err SHALL be 0 for every in_len>0 result and SHALL clear on the DONE->IDLE handshake.

Reset
REQ-031 in_rst_n low SHALL immediately force IDLE; out_busy, out_data_ready, out_result_valid, out_err = 0; out_result, out_result_idx, counter, candidate = 0.
REQ-032 Reset mid-reduction SHALL discard all progress; first operation after release requires a new in_start.

Verification
REQ-033 Max, len=4: stream 1.0(0x3FF0000000000000), 2.0(0x4000000000000000), -3.0(0xC008000000000000), 1.5(0x3FF8000000000000) -> out_result=0x4000000000000000, idx=1, valid one cycle after 4th transfer.
REQ-034 Min, same stream -> out_result=0xC008000000000000, idx=2.
REQ-035 Min, len=2: +0 (0x0) then -0 (0x8000000000000000) -> result 0x8000000000000000, idx=1; max on same stream -> 0x0, idx=0; max on 2.0,2.0 -> idx=0.
REQ-036 len=0 start -> next cycle out_result_valid=1, out_err=1, result=0; in_result_ready=1 -> IDLE, out_err=0.
REQ-037 Backpressure: in_data_valid toggling 1/0 and in_result_ready held 0 for 5 cycles -> no extra transfers, outputs stable, in_start ignored while busy.
REQ-038 Assert in_rst_n=0 after 2 of 4 elements -> all outputs 0 same cycle; new start of len=1 with 1.0 -> result 0x3FF0000000000000, idx=0.

Source files
------------

// File: rtl/fp_minmax_reduce.sv
// fp_minmax_reduce: streaming min/max reduction over IEEE-754 operands.
// The element order is sign-magnitude on raw bit patterns. The result is the
// selected element and its zero-based position in the stream. When two
// elements tie, the earlier one is kept.
module fp_minmax_reduce #(
    parameter int DATA_WIDTH = 64,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  in_clk,
    input  logic                  in_rst_n,
    input  logic                  in_start,
    input  logic                  in_ctrl_minmax,
    input  logic [CNT_WIDTH-1:0]  in_len,
    input  logic                  in_data_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_data_ready,
    output logic                  out_busy,
    output logic                  out_result_valid,
    output logic [DATA_WIDTH-1:0] out_result,
    output logic [CNT_WIDTH-1:0]  out_result_idx,
    output logic                  out_err,
    input  logic                  in_result_ready
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FIRST = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]            state_q,    state_d;
    logic                  op_max_q,   op_max_d;
    logic [CNT_WIDTH-1:0]  len_q,      len_d;
    logic [CNT_WIDTH-1:0]  cnt_q,      cnt_d;
    logic [DATA_WIDTH-1:0] cand_q,     cand_d;
    logic [CNT_WIDTH-1:0]  cand_idx_q, cand_idx_d;
    logic                  err_q,      err_d;

    logic                  xfer;
    logic                  better;
    logic [CNT_WIDTH-1:0]  cnt_inc;

    // Returns 1 when a is strictly above b in sign-magnitude order.
    // Under this order -0 < +0. NaN and Inf get no special handling.
    function automatic logic fp_gt(input logic [DATA_WIDTH-1:0] a,
                                   input logic [DATA_WIDTH-1:0] b);
        logic                  sa, sb;
        logic [DATA_WIDTH-2:0] ma, mb;
        sa = a[DATA_WIDTH-1];
        sb = b[DATA_WIDTH-1];
        ma = a[DATA_WIDTH-2:0];
        mb = b[DATA_WIDTH-2:0];
        if (sa != sb)
            fp_gt = sb;          // a positive, b negative -> a is greater
        else if (!sa)
            fp_gt = (ma > mb);
        else
            fp_gt = (ma < mb);   // both negative: larger magnitude is smaller
    endfunction

    assign out_data_ready   = (state_q == S_FIRST) || (state_q == S_RUN);
    assign out_busy         = (state_q != S_IDLE);
    assign out_result_valid = (state_q == S_DONE);
    assign out_result       = cand_q;
    assign out_result_idx   = cand_idx_q;
    assign out_err          = err_q;

    assign xfer    = in_data_valid && out_data_ready;
    assign cnt_inc = cnt_q + CNT_WIDTH'(1);

    // Next-state and datapath update for the reduction FSM.
    always_comb begin
        state_d    = state_q;
        op_max_d   = op_max_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        cand_d     = cand_q;
        cand_idx_d = cand_idx_q;
        err_d      = err_q;
        better     = op_max_q ? fp_gt(in_data, cand_q) : fp_gt(cand_q, in_data);

        case (state_q)
            S_IDLE: begin
                if (in_start) begin
                    // Operation and length are captured here. Later changes
                    // to in_ctrl_minmax or in_len do not affect this run.
                    op_max_d   = in_ctrl_minmax;
                    len_d      = in_len;
                    cnt_d      = '0;
                    cand_d     = '0;
                    cand_idx_d = '0;
                    if (in_len == '0) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = S_FIRST;
                    end
                end
            end
            S_FIRST: begin
                if (xfer) begin
                    cand_d     = in_data;
                    cand_idx_d = '0;
                    cnt_d      = CNT_WIDTH'(1);
                    state_d    = (len_q > CNT_WIDTH'(1)) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (xfer) begin
                    if (better) begin
                        cand_d     = in_data;
                        cand_idx_d = cnt_q;
                    end
                    // Here cnt_q < len_q, so cnt_inc cannot wrap even at the
                    // largest length.
                    cnt_d = cnt_inc;
                    if (cnt_inc == len_q)
                        state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (in_result_ready) begin
                    state_d = S_IDLE;
                    err_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers. Reset clears all state, control and data alike.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q    <= S_IDLE;
            op_max_q   <= 1'b0;
            len_q      <= '0;
            cnt_q      <= '0;
            cand_q     <= '0;
            cand_idx_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_max_q   <= op_max_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            cand_q     <= cand_d;
            cand_idx_q <= cand_idx_d;
            err_q      <= err_d;
        end
    end

endmodule
